// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encodings and default width.
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor; master issues operands, slave returns the result.
interface serial_subtractor_if #(
   parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output start, a_in, b_in,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a_in, b_in,
      output busy, done, diff, borrow
   );
endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit combinational full subtractor: x - y - bin.
module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; previous diff/borrow held on outputs
//   S_SHIFT | one cell evaluation per cycle, WIDTH cycles
//   S_DONE  | result already registered; raises done on the way out
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                reset_n,
   serial_subtractor_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] d_sh;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   logic             cell_d;
   logic             cell_bout;
   logic [WIDTH-1:0] d_next;

   fs_cell u_cell (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (brw),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign d_next = {cell_d, d_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         d_sh     <= '0;
         brw      <= 1'b0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_sh   <= bus.a_in;
                  b_sh   <= bus.b_in;
                  brw    <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               d_sh <= d_next;
               brw  <= cell_bout;
               cnt  <= cnt + 1'b1;
               // Final bit: publish the assembled word and the borrow leaving the MSB.
               if (cnt == CNT_LAST) begin
                  diff_q   <= d_next;
                  borrow_q <= cell_bout;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;

endmodule
